// File: rtl/inside_range_pkg.sv
// Shared types for the inside-style range-membership scanner.
// The table entry and FSM state types live here so the scanner top and the
// range comparator agree on one layout.
package inside_range_pkg;

  // Widest value/bound a table entry stores. The scanner's DATA_W must not
  // exceed this; narrower values are zero-extended into the entry, which
  // keeps the unsigned ordering unchanged.
  localparam int ENTRY_W = 8;

  // One inclusive range [lo:hi]. A cleared entry (en=0) never matches.
  typedef struct packed {
    logic               en;
    logic [ENTRY_W-1:0] lo;
    logic [ENTRY_W-1:0] hi;
  } range_entry_t;

  // Scanner sequencing: wait for a value, walk the table, hold the answer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } scan_state_e;

  // Build a table entry from already-widened bounds.
  function automatic range_entry_t make_entry(input logic               en,
                                              input logic [ENTRY_W-1:0] lo,
                                              input logic [ENTRY_W-1:0] hi);
    range_entry_t e;
    e.en = en;
    e.lo = lo;
    e.hi = hi;
    return e;
  endfunction

endpackage

// File: rtl/inside_range_scanner_cmp.sv
// range_cmp: purely combinational inclusive range test for one table entry.
// An entry whose lo is above hi can never satisfy both bounds, so inverted
// entries fall out as "never match" without extra logic.
module range_cmp
  import inside_range_pkg::*;
(
  input  range_entry_t       entry,
  input  logic [ENTRY_W-1:0] data,
  output logic               match
);

  // Unsigned, inclusive on both ends, gated by the entry enable.
  assign match = entry.en && (entry.lo <= data) && (data <= entry.hi);

endmodule

// File: rtl/inside_range_scanner.sv
// inside_range_scanner: takes one value per request, finds the lowest-index
// enabled table range containing it, and returns hit/index on a response
// channel. The range table is written by a control master at any time.
//
// Build option: define RANGE_SCAN_PARALLEL_EN to compare every entry in a
// single SCAN cycle through a priority encoder. Left undefined, the table is
// walked one entry per cycle. Ports and response values are identical in both.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a valid source holds its payload until that edge, and ready
// never depends combinationally on valid (both ready and rsp_valid are
// registered here).
module inside_range_scanner
  import inside_range_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int NUM_RANGES = 4,
  localparam int IDX_W      = $clog2(NUM_RANGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [DATA_W-1:0] cfg_lo,
  input  logic [DATA_W-1:0] cfg_hi,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [IDX_W-1:0]  rsp_idx
);

  scan_state_e        state;
  range_entry_t       entries_q [NUM_RANGES];
  logic [ENTRY_W-1:0] data_q;

  // Result of the current SCAN cycle, produced by whichever scan build is in use.
  logic               scan_hit;
  logic [IDX_W-1:0]   scan_idx;
  logic               scan_last;

  // A write to an index beyond the table (non power-of-two sizes) is dropped.
  logic               cfg_idx_ok;
  assign cfg_idx_ok = ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_RANGES));

  // Range table: cleared by reset, writable in every state. The scan reads the
  // registered copy, so a write landing on the entry being compared this edge
  // only becomes visible from the next edge onwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RANGES; i++) begin
        entries_q[i] <= '0;
      end
    end else if (cfg_we && cfg_idx_ok) begin
      entries_q[cfg_idx] <= make_entry(cfg_en, ENTRY_W'(cfg_lo), ENTRY_W'(cfg_hi));
    end
  end

`ifdef RANGE_SCAN_PARALLEL_EN

  logic [NUM_RANGES-1:0] match_vec;

  for (genvar g = 0; g < NUM_RANGES; g++) begin : g_cmp
    range_cmp u_cmp (
      .entry (entries_q[g]),
      .data  (data_q),
      .match (match_vec[g])
    );
  end

  // Priority encoder: the lowest matching index wins; a miss reports index 0.
  always_comb begin
    scan_idx = '0;
    for (int i = NUM_RANGES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        scan_idx = IDX_W'(i);
      end
    end
  end

  assign scan_hit  = |match_vec;
  // Every entry is examined at once, so the first SCAN cycle is also the last.
  assign scan_last = 1'b1;

`else

  logic [IDX_W-1:0] ptr_q;
  logic             cur_match;

  range_cmp u_cmp (
    .entry (entries_q[ptr_q]),
    .data  (data_q),
    .match (cur_match)
  );

  // Scan pointer: parked at entry 0 outside SCAN, advances while the walk continues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state != SCAN) begin
      ptr_q <= '0;
    end else if (!cur_match && !scan_last) begin
      ptr_q <= ptr_q + IDX_W'(1);
    end
  end

  assign scan_hit  = cur_match;
  assign scan_idx  = ptr_q;
  assign scan_last = (ptr_q == IDX_W'(NUM_RANGES - 1));

`endif

  // Request/scan/response sequencer with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // First IDLE cycle after reset raises ready; later visits enter with it set.
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            data_q    <= ENTRY_W'(req_data);
            req_ready <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (scan_hit || scan_last) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_hit   <= scan_hit;
            rsp_idx   <= scan_hit ? scan_idx : '0;
          end
        end
        RESP: begin
          // Result stays frozen until the consumer takes it; no new request here.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_idx   <= '0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inside_range_scanner.sv
// Self-checking bench for inside_range_scanner (DATA_W=3, NUM_RANGES=4).
// Expected responses are pushed to a queue as requests go in and popped when
// the scanner answers. Latency expectations follow RANGE_SCAN_PARALLEL_EN.
module tb_inside_range_scanner;

  localparam int DATA_W     = 3;
  localparam int NUM_RANGES = 4;
  localparam int IDX_W      = 2;
  localparam int EXP_W      = 1 + IDX_W + 8;

`ifdef RANGE_SCAN_PARALLEL_EN
  localparam bit PARALLEL = 1'b1;
`else
  localparam bit PARALLEL = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic              cfg_en;
  logic [DATA_W-1:0] cfg_lo;
  logic [DATA_W-1:0] cfg_hi;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [IDX_W-1:0]  rsp_idx;

  // Scoreboard entry: {hit, idx, latency[7:0]}
  logic [EXP_W-1:0] exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;

  // Reference copy of the range table
  logic              m_en [NUM_RANGES];
  logic [DATA_W-1:0] m_lo [NUM_RANGES];
  logic [DATA_W-1:0] m_hi [NUM_RANGES];

  inside_range_scanner #(
    .DATA_W     (DATA_W),
    .NUM_RANGES (NUM_RANGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_en    (cfg_en),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_idx   (rsp_idx)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle in which rsp_valid first rises
  always @(negedge clk) begin
    if (rsp_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rsp_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_RANGES; i++) begin
      m_en[i] = 1'b0;
      m_lo[i] = '0;
      m_hi[i] = '0;
    end
  endtask

  function automatic logic [EXP_W-1:0] mk_exp(input logic hit, input logic [IDX_W-1:0] idx,
                                              input int seq_lat);
    int lat;
    lat = PARALLEL ? 1 : seq_lat;
    return {hit, idx, 8'(lat)};
  endfunction

  function automatic logic [EXP_W-1:0] model_exp(input logic [DATA_W-1:0] d);
    logic             hit;
    logic [IDX_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_RANGES - 1; i >= 0; i--) begin
      if (m_en[i] && (m_lo[i] <= d) && (d <= m_hi[i])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    return mk_exp(hit, idx, hit ? int'(idx) + 1 : NUM_RANGES);
  endfunction

  task automatic cfg_write(input int idx, input logic en, input int lo, input int hi);
    cfg_we  = 1'b1;
    cfg_idx = IDX_W'(idx);
    cfg_en  = en;
    cfg_lo  = DATA_W'(lo);
    cfg_hi  = DATA_W'(hi);
    cycle();
    cfg_we  = 1'b0;
    m_en[idx] = en;
    m_lo[idx] = DATA_W'(lo);
    m_hi[idx] = DATA_W'(hi);
  endtask

  task automatic issue_req(input string name, input int d);
    int waited;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      cycle();
      waited++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready: got %b, required 1 within 20 cycles", name, req_ready);
    end
    req_valid = 1'b1;
    req_data  = DATA_W'(d);
    cycle();
    accept_cyc = cyc;
    req_valid  = 1'b0;
    req_data   = DATA_W'($urandom_range(0, 7));
  endtask

  // Wait for the response, compare against the queue head, optionally hold
  // backpressure for 'hold' cycles, then complete the handshake.
  task automatic wait_rsp(input string name, input int hold);
    logic [EXP_W-1:0] exp;
    int               waited;
    int               lat;
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < 40) begin
      cycle();
      waited++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: rsp_valid=%b after %0d cycles, required 1", name, rsp_valid, waited);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected response: hit=%b idx=%0d with empty queue", name, rsp_hit, rsp_idx);
      return;
    end
    exp = exp_q.pop_front();
    @(negedge clk);
    #1;
    lat = rise_cyc - accept_cyc;
    checks++;
    if ({rsp_hit, rsp_idx} !== exp[EXP_W-1:8]) begin
      errors++;
      $display("FAIL %s result: got hit=%b idx=%0d, required hit=%b idx=%0d",
               name, rsp_hit, rsp_idx, exp[EXP_W-1], exp[EXP_W-2 -: IDX_W]);
    end
    checks++;
    if (lat != int'(exp[7:0])) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, exp[7:0]);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s req_ready in RESP: got %b, required 0", name, req_ready);
    end
    for (int i = 0; i < hold; i++) begin
      cycle();
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {rsp_hit, rsp_idx} !== exp[EXP_W-1:8]) begin
        errors++;
        $display("FAIL %s stall %0d: got valid=%b ready=%b hit=%b idx=%0d, required valid=1 ready=0 hit=%b idx=%0d",
                 name, i, rsp_valid, req_ready, rsp_hit, rsp_idx, exp[EXP_W-1], exp[EXP_W-2 -: IDX_W]);
      end
    end
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got rsp_valid=%b req_ready=%b, required 0 and 1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic run_model(input string name, input int d, input int hold);
    exp_q.push_back(model_exp(DATA_W'(d)));
    issue_req(name, d);
    wait_rsp(name, hold);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    cycle();
    cycle();
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_idx !== '0) begin
      errors++;
      $display("FAIL reset outputs: got ready=%b valid=%b hit=%b idx=%0d, required all 0",
               req_ready, rsp_valid, rsp_hit, rsp_idx);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset release: got ready=%b valid=%b, required 1 and 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_single_range();
    cfg_write(0, 1'b1, 4, 6);
    run_model("single_5", 5, 0);
    run_model("single_lo_4", 4, 0);
    run_model("single_hi_6", 6, 0);
    run_model("single_miss_7", 7, 0);
    run_model("single_miss_3", 3, 0);
  endtask

  task automatic test_priority();
    cfg_write(2, 1'b1, 0, 3);
    run_model("prio_3_idx2", 3, 0);
    cfg_write(1, 1'b1, 5, 2);
    run_model("inverted_3", 3, 0);
    run_model("inverted_5", 5, 0);
    cfg_write(1, 1'b1, 7, 7);
    run_model("single_value_7", 7, 0);
    run_model("single_value_6", 6, 0);
  endtask

  task automatic test_backpressure();
    run_model("backpressure", 5, 5);
  endtask

  task automatic test_cfg_during_scan();
    cfg_write(1, 1'b0, 0, 0);
    // entry3 is written while the walk is at entry 1 (not yet scanned) and
    // entry0 is rewritten at entry 2 (already scanned). The parallel build
    // has already answered from the old table by then.
    if (PARALLEL) exp_q.push_back(mk_exp(1'b0, 2'd0, 1));
    else          exp_q.push_back(mk_exp(1'b1, 2'd3, 4));
    issue_req("cfg_scan", 7);
    cycle();
    cfg_write(3, 1'b1, 0, 7);
    cfg_write(0, 1'b1, 7, 7);
    wait_rsp("cfg_scan", 0);
    run_model("cfg_after_7", 7, 0);
    run_model("cfg_after_6", 6, 0);
  endtask

  task automatic test_reset_mid_scan();
    issue_req("abort", 2);
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort during rst: got valid=%b ready=%b, required 0 and 0", rsp_valid, req_ready);
    end
    cycle();
    cycle();
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort no response %0d: got rsp_valid=%b, required 0", i, rsp_valid);
      end
    end
    run_model("after_abort_5", 5, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_write(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
      run_model("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end
  endtask

  // ---------------- main sequence + final report ----------------
  initial begin
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_en = 1'b0;
    cfg_lo = '0;
    cfg_hi = '0;
    req_valid = 1'b0;
    req_data = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_range();
    test_priority();
    test_backpressure();
    test_cfg_during_scan();
    test_reset_mid_scan();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
